axis_packet_fifo: RTL and testbench
===================================

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: tdata width in bits.
REQ-002 SHALL have parameter DEPTH, default 4096: storage entries; legal range 2 or more; need not be a power of 2.
REQ-003 SHALL have parameter PACKET_MODE, default 0: 1 means output is gated until a complete packet is stored.
REQ-004 SHALL have parameter ALMOST_FULL_THRESH, default DEPTH-1, and parameter ALMOST_EMPTY_THRESH, default 1.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port arstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port s_axis_tdata, input, DATA_WIDTH bits: input beat data.
REQ-008 SHALL have ports s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1): input handshake and end-of-packet.
REQ-009 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tlast (output, 1), m_axis_tvalid (output, 1) and m_axis_tready (input, 1): output handshake.
REQ-010 SHALL have port fill_level, output, $clog2(DEPTH+1) bits: entries currently stored.
REQ-011 SHALL have ports almost_full (output, 1), almost_empty (output, 1) and oversize (output, 1): status flags.

Function
REQ-012 SHALL store {tlast, tdata} per entry in a circular array; wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
REQ-013 SHALL define push = s_axis_tvalid && s_axis_tready and pop = m_axis_tvalid && m_axis_tready.
REQ-014 SHALL drive s_axis_tready = (fill_level < DEPTH), with no combinational dependence on m_axis_tready.
REQ-015 SHALL update fill_level by +push and -pop each cycle; a simultaneous push and pop leaves it unchanged.
REQ-016 SHALL present m_axis_tdata and m_axis_tlast combinationally from entry rd_ptr (first-word fall-through), with no input-to-output bypass.
REQ-017 SHALL give a latency of 1 cycle: a beat accepted at edge N is visible with m_axis_tvalid high after edge N.
REQ-018 SHALL, when PACKET_MODE=0, drive m_axis_tvalid = (fill_level > 0).
REQ-019 SHALL keep pkt_count, $clog2(DEPTH+1) bits: +1 on a push with tlast, -1 on a pop with tlast; both in one cycle leave it unchanged.
REQ-020 SHALL, when PACKET_MODE=1, run a two-state FSM with states GATED and FORCED; reset state is GATED.
REQ-021 SHALL, in GATED, drive m_axis_tvalid = (pkt_count > 0).
REQ-022 SHALL, in FORCED, drive m_axis_tvalid = (fill_level > 0).
REQ-023 SHALL transition GATED to FORCED when fill_level == DEPTH and pkt_count == 0, preventing deadlock on packets longer than DEPTH.
REQ-024 SHALL transition FORCED to GATED on a pop whose tlast is 1.
REQ-025 SHALL make oversize a sticky flag, set on entry to FORCED and cleared only by reset.
REQ-026 SHALL drive almost_full = (fill_level >= ALMOST_FULL_THRESH) and almost_empty = (fill_level <= ALMOST_EMPTY_THRESH), both combinational from registered state.
REQ-027 SHALL require that m_axis_tdata, m_axis_tlast and m_axis_tvalid, once valid, stay stable until the pop occurs (AXI-Stream rule).
REQ-028 SHALL tie the FSM to GATED with oversize 0 when PACKET_MODE=0; pkt_count may still be maintained.

Reset
REQ-029 SHALL, on arstn low, asynchronously clear wr_ptr, rd_ptr, fill_level and pkt_count, set the FSM to GATED and clear oversize.
REQ-030 SHALL give reset output values m_axis_tvalid=0, s_axis_tready=1, fill_level=0, almost_empty=1, almost_full=0 (for thresholds ≥1), oversize=0.
REQ-031 SHALL discard all stored data when reset is asserted mid-packet; array contents are not cleared.

Structure
REQ-032 SHALL use no shared package; pointer and count widths are derived locally with $clog2.
REQ-033 SHALL place storage in one sub-module, sdp_ram (simple dual-port, synchronous write, asynchronous read, block-RAM hint), DATA_WIDTH+1 bits wide.

Verification
REQ-034 SHALL cover: DEPTH=4, PACKET_MODE=0, push 4 beats with m_axis_tready=0 -> fill_level=4, s_axis_tready=0, almost_full=1; then drain -> data comes out in order.
REQ-035 SHALL cover: continuous push and pop at fill_level=2 for 10 cycles -> fill_level stays 2 and the pointers wrap correctly.
REQ-036 SHALL cover: PACKET_MODE=1, push 3 beats with tlast on the third -> m_axis_tvalid stays 0 until the cycle after the third push.
REQ-037 SHALL cover: PACKET_MODE=1, DEPTH=4, a 6-beat packet -> FORCED entered and oversize=1; all 6 beats delivered; GATED resumes after the tlast pop.
REQ-038 SHALL cover: arstn pulsed low with fill_level=3 -> fill_level=0 and m_axis_tvalid=0 immediately, with no clock edge needed.
REQ-039 SHALL cover: ALMOST_EMPTY_THRESH=1 with fill_level going 0->1->2 -> almost_empty reads 1, 1, 0.

Source files
------------

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Simple dual-port storage array: one synchronous write port, one
// asynchronous (combinational) read port.
//
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
// -----------------------------------------------------------------------------
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is combinational so the FIFO head is visible without a cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// -----------------------------------------------------------------------------
// axis_packet_fifo
// AXI-Stream FIFO with first-word fall-through output and an optional packet
// mode that withholds output until a whole packet (tlast) has been stored.
// A packet larger than the FIFO forces the output open so it cannot deadlock;
// that event is latched in the sticky oversize flag.
//
// Ports:
//   clk, arstn            - clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast/tready - input stream
//   m_axis_tdata/tvalid/tlast/tready - output stream
//   fill_level            - number of entries stored
//   almost_full           - fill_level >= ALMOST_FULL_THRESH
//   almost_empty          - fill_level <= ALMOST_EMPTY_THRESH
//   oversize              - a packet longer than DEPTH was seen (sticky)
// -----------------------------------------------------------------------------
module axis_packet_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int DEPTH               = 4096,
  parameter int PACKET_MODE         = 0,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C       = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_C       = CW'(ALMOST_EMPTY_THRESH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
  localparam bit            PKT_MODE   = (PACKET_MODE != 0);

  localparam logic [0:0] GATED  = 1'b0;
  localparam logic [0:0] FORCED = 1'b1;

  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         fill_r;
  logic [CW-1:0]         pkt_r;
  logic [0:0]            state_r;
  logic [0:0]            state_nxt_s;
  logic                  enter_forced_s;
  logic                  oversize_r;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH:0]   rd_word_s;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == LAST_PTR) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  sdp_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rd_ptr_r),
    .rdata (rd_word_s)
  );

  // Readiness depends only on stored state, never on m_axis_tready.
  assign s_axis_tready = (fill_r < DEPTH_C);
  assign push_s        = s_axis_tvalid && s_axis_tready;
  assign pop_s         = m_axis_tvalid && m_axis_tready;

  assign m_axis_tdata  = rd_word_s[DATA_WIDTH-1:0];
  assign m_axis_tlast  = rd_word_s[DATA_WIDTH];

  assign fill_level    = fill_r;
  assign almost_full   = (fill_r >= AF_C);
  assign almost_empty  = (fill_r <= AE_C);
  assign oversize      = oversize_r;

  // Output valid: plain occupancy, or whole-packet gating in packet mode.
  always_comb begin
    m_axis_tvalid = 1'b0;
    if (!PKT_MODE) begin
      m_axis_tvalid = (fill_r != {CW{1'b0}});
    end else if (state_r == GATED) begin
      m_axis_tvalid = (pkt_r != {CW{1'b0}});
    end else begin
      m_axis_tvalid = (fill_r != {CW{1'b0}});
    end
  end

  // Gate FSM: a full FIFO with no complete packet must be forced open,
  // otherwise the writer could never deliver the tlast beat.
  always_comb begin
    state_nxt_s    = state_r;
    enter_forced_s = 1'b0;
    if (!PKT_MODE) begin
      state_nxt_s = GATED;
    end else if (state_r == GATED) begin
      if ((fill_r == DEPTH_C) && (pkt_r == {CW{1'b0}})) begin
        state_nxt_s    = FORCED;
        enter_forced_s = 1'b1;
      end else begin
        state_nxt_s = GATED;
      end
    end else begin
      if (pop_s && m_axis_tlast) begin
        state_nxt_s = GATED;
      end else begin
        state_nxt_s = FORCED;
      end
    end
  end

  // Pointers, occupancy, packet count, FSM state and sticky oversize flag.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fill_r     <= {CW{1'b0}};
      pkt_r      <= {CW{1'b0}};
      state_r    <= GATED;
      oversize_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + CW'(1);
        2'b01:   fill_r <= fill_r - CW'(1);
        default: fill_r <= fill_r;
      endcase
      case ({push_s && s_axis_tlast, pop_s && m_axis_tlast})
        2'b10:   pkt_r <= pkt_r + CW'(1);
        2'b01:   pkt_r <= pkt_r - CW'(1);
        default: pkt_r <= pkt_r;
      endcase
      state_r <= state_nxt_s;
      if (enter_forced_s) begin
        oversize_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_fifo
// Directed bench: u0 is a DEPTH=4 streaming FIFO, u1 a DEPTH=4 packet FIFO.
// -----------------------------------------------------------------------------
module tb_axis_packet_fifo;

  logic       clk;
  logic       arstn;

  logic [7:0] a_s_tdata, a_m_tdata;
  logic       a_s_tvalid, a_s_tlast, a_s_tready;
  logic       a_m_tvalid, a_m_tlast, a_m_tready;
  logic [2:0] a_fill;
  logic       a_af, a_ae, a_ovs;

  logic [7:0] b_s_tdata, b_m_tdata;
  logic       b_s_tvalid, b_s_tlast, b_s_tready;
  logic       b_m_tvalid, b_m_tlast, b_m_tready;
  logic [2:0] b_fill;
  logic       b_af, b_ae, b_ovs;

  int n_chk;
  int n_fail;

  axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(4), .PACKET_MODE(0)) u0 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tlast(a_s_tlast), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tlast(a_m_tlast),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .fill_level(a_fill), .almost_full(a_af), .almost_empty(a_ae),
    .oversize(a_ovs)
  );

  axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(4), .PACKET_MODE(1)) u1 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tlast(b_s_tlast), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tlast(b_m_tlast),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .fill_level(b_fill), .almost_full(b_af), .almost_empty(b_ae),
    .oversize(b_ovs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d34 [4];
    int src;
    logic rdy;
    d34[0] = 8'h11; d34[1] = 8'h22; d34[2] = 8'h33; d34[3] = 8'h44;
    n_chk = 0;
    n_fail = 0;
    arstn = 1'b0;
    a_s_tdata = 8'h00; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b0;
    b_s_tdata = 8'h00; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_tvalid", a_m_tvalid, 0);
    chk("rst_tready", a_s_tready, 1);
    chk("rst_fill", a_fill, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_ovs", a_ovs, 0);
    chk("rst_b_tvalid", b_m_tvalid, 0);
    chk("rst_b_ovs", b_ovs, 0);
    arstn = 1'b1;
    tick();

    // Fill to DEPTH with output stalled, then drain in order
    a_s_tvalid = 1'b1; a_s_tdata = 8'h11;
    tick();
    chk("fill1", a_fill, 1);
    chk("lat1_tvalid", a_m_tvalid, 1);
    chk("ae_at1", a_ae, 1);
    chk("fwft_head", a_m_tdata, 8'h11);
    a_s_tdata = 8'h22;
    tick();
    chk("fill2", a_fill, 2);
    chk("ae_at2", a_ae, 0);
    chk("af_at2", a_af, 0);
    a_s_tdata = 8'h33;
    tick();
    chk("af_at3", a_af, 1);
    a_s_tdata = 8'h44; a_s_tlast = 1'b1;
    tick();
    chk("fill4", a_fill, 4);
    chk("full_tready", a_s_tready, 0);
    chk("full_af", a_af, 1);
    chk("full_head", a_m_tdata, 8'h11);
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", a_m_tdata, d34[i]);
      chk("drain_last", a_m_tlast, (i == 3) ? 1 : 0);
      tick();
    end
    chk("drained_fill", a_fill, 0);
    chk("drained_tvalid", a_m_tvalid, 0);

    // Steady push+pop at fill_level 2, pointers wrap
    a_m_tready = 1'b0; a_s_tvalid = 1'b1;
    a_s_tdata = 8'hA0;
    tick();
    a_s_tdata = 8'hA1;
    tick();
    a_m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_s_tdata = 8'(8'hA2 + i);
      chk("stream_data", a_m_tdata, 8'(8'hA0 + i));
      tick();
      chk("stream_fill", a_fill, 2);
    end
    a_s_tvalid = 1'b0;
    chk("tail0", a_m_tdata, 8'hAA);
    tick();
    chk("tail1", a_m_tdata, 8'hAB);
    tick();
    chk("tail_fill", a_fill, 0);
    a_m_tready = 1'b0;

    // Packet mode: output gated until tlast stored
    b_s_tvalid = 1'b1; b_s_tdata = 8'h31;
    tick();
    chk("pkt_gate1", b_m_tvalid, 0);
    b_s_tdata = 8'h32;
    tick();
    chk("pkt_gate2", b_m_tvalid, 0);
    b_s_tdata = 8'h33; b_s_tlast = 1'b1;
    tick();
    chk("pkt_open", b_m_tvalid, 1);
    chk("pkt_head", b_m_tdata, 8'h31);
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
    chk("pkt_d0", b_m_tdata, 8'h31);
    tick();
    chk("pkt_d1", b_m_tdata, 8'h32);
    tick();
    chk("pkt_d2", b_m_tdata, 8'h33);
    chk("pkt_l2", b_m_tlast, 1);
    tick();
    chk("pkt_done_tvalid", b_m_tvalid, 0);
    b_m_tready = 1'b0;

    // Oversize packet: 6 beats into 4 entries
    b_s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_s_tdata = 8'(8'h60 + i);
      tick();
    end
    b_s_tdata = 8'h64;
    chk("ovs_full_fill", b_fill, 4);
    chk("ovs_full_tready", b_s_tready, 0);
    chk("ovs_pre_tvalid", b_m_tvalid, 0);
    chk("ovs_pre_flag", b_ovs, 0);
    tick();
    chk("ovs_flag", b_ovs, 1);
    chk("ovs_forced_tvalid", b_m_tvalid, 1);
    chk("ovs_head", b_m_tdata, 8'h60);
    b_m_tready = 1'b1;
    src = 4;
    for (int i = 0; i < 6; i++) begin
      b_s_tvalid = (src < 6);
      b_s_tdata = 8'(8'h60 + src);
      b_s_tlast = (src == 5);
      chk("ovs_data", b_m_tdata, 8'(8'h60 + i));
      chk("ovs_last", b_m_tlast, (i == 5) ? 1 : 0);
      rdy = b_s_tready;
      tick();
      if (b_s_tvalid && rdy) src++;
    end
    chk("ovs_src_all", src, 6);
    chk("ovs_empty_fill", b_fill, 0);
    chk("ovs_empty_tvalid", b_m_tvalid, 0);
    // Back in GATED: a partial packet must not be presented
    b_m_tready = 1'b0;
    b_s_tvalid = 1'b1; b_s_tdata = 8'h70; b_s_tlast = 1'b0;
    tick();
    b_s_tvalid = 1'b0;
    chk("regated_fill", b_fill, 1);
    chk("regated_tvalid", b_m_tvalid, 0);
    chk("ovs_sticky", b_ovs, 1);

    // Asynchronous reset with data stored
    a_s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_s_tdata = 8'(8'h51 + i);
      tick();
    end
    a_s_tvalid = 1'b0;
    chk("pre_rst_fill", a_fill, 3);
    #2;
    arstn = 1'b0;
    #1;
    chk("arst_fill", a_fill, 0);
    chk("arst_tvalid", a_m_tvalid, 0);
    chk("arst_tready", a_s_tready, 1);
    chk("arst_b_fill", b_fill, 0);
    chk("arst_b_ovs", b_ovs, 0);
    #10;
    arstn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
